// File: rtl/snow64_param_instr_cache.sv
// Direct-mapped read-only instruction cache: 1-cycle hit, whole-line refill on a miss, multi-cycle flush.
// Latency: a hit returns on the next edge, a miss one edge after the fill data; while out_busy is high, requests and flushes are ignored and must be held.
module snow64_param_instr_cache #(
  parameter int ADDR_WIDTH  = 64,
  parameter int INSTR_WIDTH = 32,
  parameter int LINE_WIDTH  = 256,
  parameter int NUM_LINES   = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_req_read_req,
  input  logic [ADDR_WIDTH-1:0]  in_req_read_addr,
  output logic                   out_req_read_valid,
  output logic [INSTR_WIDTH-1:0] out_req_read_instr,
  output logic                   out_busy,
  output logic                   out_mem_access_req,
  output logic [ADDR_WIDTH-1:0]  out_mem_access_addr,
  input  logic                   in_mem_access_valid,
  input  logic [LINE_WIDTH-1:0]  in_mem_access_data,
  input  logic                   in_flush_req
);

  localparam int OFF_BITS  = $clog2(LINE_WIDTH / 8);
  localparam int WORD_BITS = $clog2(LINE_WIDTH / INSTR_WIDTH);
  localparam int IDX_BITS  = $clog2(NUM_LINES);
  localparam int TAG_BITS  = ADDR_WIDTH - OFF_BITS - IDX_BITS;
  localparam int LINE_BITS = ADDR_WIDTH - OFF_BITS;

  typedef enum logic [1:0] {IDLE, FILL, FLUSH} state_t;

  state_t                 state, next_state;
  logic [NUM_LINES-1:0]   valid_bits;
  logic [IDX_BITS-1:0]    flush_cnt;
  logic [LINE_WIDTH-1:0]  line_array [NUM_LINES];
  logic [TAG_BITS-1:0]    tag_array  [NUM_LINES];
  logic [LINE_BITS-1:0]   miss_line;
  logic [OFF_BITS-1:0]    miss_word;
  logic                   rd_valid;
  logic [INSTR_WIDTH-1:0] rd_instr;
  logic                   hit;
  logic                   accept_hit;

  // Shifting the whole offset field keeps byte-lane bits out of the word select for any INSTR_WIDTH.
  logic [TAG_BITS-1:0] req_tag;
  logic [IDX_BITS-1:0] req_idx;
  logic [OFF_BITS-1:0] req_word;
  logic [IDX_BITS-1:0] miss_idx;
  logic [TAG_BITS-1:0] miss_tag;

  assign req_tag  = in_req_read_addr[ADDR_WIDTH-1:OFF_BITS+IDX_BITS];
  assign req_idx  = in_req_read_addr[OFF_BITS+IDX_BITS-1:OFF_BITS];
  assign req_word = in_req_read_addr[OFF_BITS-1:0] >> (OFF_BITS - WORD_BITS);
  assign miss_idx = miss_line[IDX_BITS-1:0];
  assign miss_tag = miss_line[LINE_BITS-1:IDX_BITS];
  assign hit      = valid_bits[req_idx] && (tag_array[req_idx] == req_tag);

  always_comb begin
    next_state = state;
    accept_hit = 1'b0;
    case (state)
      IDLE: begin
        if (in_flush_req) begin
          next_state = FLUSH;
        end else if (in_req_read_req) begin
          if (hit) accept_hit = 1'b1;
          else     next_state = FILL;
        end
      end
      FILL:    if (in_mem_access_valid) next_state = IDLE;
      FLUSH:   if (flush_cnt == IDX_BITS'(NUM_LINES - 1)) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      valid_bits <= '0;
      flush_cnt  <= '0;
      rd_valid   <= 1'b0;
      rd_instr   <= '0;
      miss_line  <= '0;
      miss_word  <= '0;
    end else begin
      state    <= next_state;
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_flush_req) begin
            flush_cnt <= '0;
          end else if (accept_hit) begin
            rd_valid <= 1'b1;
            rd_instr <= line_array[req_idx][req_word*INSTR_WIDTH +: INSTR_WIDTH];
          end else if (in_req_read_req) begin
            miss_line <= in_req_read_addr[ADDR_WIDTH-1:OFF_BITS];
            miss_word <= req_word;
          end
        end
        FILL: begin
          if (in_mem_access_valid) begin
            valid_bits[miss_idx] <= 1'b1;
            rd_valid             <= 1'b1;
            rd_instr             <= in_mem_access_data[miss_word*INSTR_WIDTH +: INSTR_WIDTH];
          end
        end
        FLUSH: begin
          valid_bits[flush_cnt] <= 1'b0;
          flush_cnt             <= flush_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Line and tag storage carry no reset; the valid flags alone decide residency.
  always_ff @(posedge clk) begin
    if (state == FILL && in_mem_access_valid) begin
      line_array[miss_idx] <= in_mem_access_data;
      tag_array[miss_idx]  <= miss_tag;
    end
  end

  assign out_req_read_valid  = rd_valid;
  assign out_req_read_instr  = rd_instr;
  assign out_busy            = (state != IDLE);
  assign out_mem_access_req  = (state == FILL);
  assign out_mem_access_addr = {miss_line, {OFF_BITS{1'b0}}};

endmodule

// File: tb/tb_snow64_param_instr_cache.sv
// Directed bench for snow64_param_instr_cache at default geometry (32 lines of 256 bits, 32-bit words).
module tb_snow64_param_instr_cache;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_req_read_req = 1'b0;
  logic [63:0]  in_req_read_addr = '0;
  logic         out_req_read_valid;
  logic [31:0]  out_req_read_instr;
  logic         out_busy;
  logic         out_mem_access_req;
  logic [63:0]  out_mem_access_addr;
  logic         in_mem_access_valid = 1'b0;
  logic [255:0] in_mem_access_data = '0;
  logic         in_flush_req = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  logic [255:0] line1000, line2000;

  always #5 clk = ~clk;

  snow64_param_instr_cache dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .in_req_read_req     (in_req_read_req),
    .in_req_read_addr    (in_req_read_addr),
    .out_req_read_valid  (out_req_read_valid),
    .out_req_read_instr  (out_req_read_instr),
    .out_busy            (out_busy),
    .out_mem_access_req  (out_mem_access_req),
    .out_mem_access_addr (out_mem_access_addr),
    .in_mem_access_valid (in_mem_access_valid),
    .in_mem_access_data  (in_mem_access_data),
    .in_flush_req        (in_flush_req)
  );

  function automatic logic [255:0] gen_line(input logic [31:0] seed);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = seed + k * 32'h0101_0101;
    return l;
  endfunction

  // Stimulus only: one-cycle fill beat after a short memory latency.
  task automatic respond(input logic [255:0] data);
    @(negedge clk);
    in_mem_access_valid = 1'b1;
    in_mem_access_data  = data;
    @(negedge clk);
    in_mem_access_valid = 1'b0;
  endtask

  task automatic issue_read(input logic [63:0] addr);
    in_req_read_req  = 1'b1;
    in_req_read_addr = addr;
    @(negedge clk);
    in_req_read_req  = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    vectors++; if (out_req_read_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %0b want 0", out_req_read_valid); end
    vectors++; if (out_req_read_instr !== 32'h0) begin miscompares++; $display("FAIL reset_instr got %h want 0", out_req_read_instr); end
    vectors++; if (out_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0b want 0", out_busy); end
    vectors++; if (out_mem_access_req !== 1'b0) begin miscompares++; $display("FAIL reset_memreq got %0b want 0", out_mem_access_req); end
    vectors++; if (out_mem_access_addr !== 64'h0) begin miscompares++; $display("FAIL reset_memaddr got %h want 0", out_mem_access_addr); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_miss_fill;
    issue_read(64'h1004);
    vectors++; if (out_mem_access_req !== 1'b1) begin miscompares++; $display("FAIL miss_memreq got %0b want 1", out_mem_access_req); end
    vectors++; if (out_mem_access_addr !== 64'h1000) begin miscompares++; $display("FAIL miss_memaddr got %h want 1000", out_mem_access_addr); end
    vectors++; if (out_busy !== 1'b1) begin miscompares++; $display("FAIL miss_busy got %0b want 1", out_busy); end
    @(negedge clk);
    vectors++; if (out_mem_access_req !== 1'b1) begin miscompares++; $display("FAIL miss_memreq_held got %0b want 1", out_mem_access_req); end
    respond(line1000);
    vectors++; if (out_req_read_valid !== 1'b1) begin miscompares++; $display("FAIL fill_valid got %0b want 1", out_req_read_valid); end
    vectors++; if (out_req_read_instr !== 32'hDEADBEEF) begin miscompares++; $display("FAIL fill_instr got %h want deadbeef", out_req_read_instr); end
    vectors++; if (out_busy !== 1'b0) begin miscompares++; $display("FAIL fill_busy got %0b want 0", out_busy); end
    vectors++; if (out_mem_access_req !== 1'b0) begin miscompares++; $display("FAIL fill_memreq got %0b want 0", out_mem_access_req); end
    @(negedge clk);
    vectors++; if (out_req_read_valid !== 1'b0) begin miscompares++; $display("FAIL fill_pulse got %0b want 0", out_req_read_valid); end
    vectors++; if (out_req_read_instr !== 32'hDEADBEEF) begin miscompares++; $display("FAIL instr_hold got %h want deadbeef", out_req_read_instr); end
  endtask

  task automatic test_hit;
    issue_read(64'h101C);
    vectors++; if (out_req_read_valid !== 1'b1) begin miscompares++; $display("FAIL hit_valid got %0b want 1", out_req_read_valid); end
    vectors++; if (out_req_read_instr !== 32'h17070707) begin miscompares++; $display("FAIL hit_instr got %h want 17070707", out_req_read_instr); end
    vectors++; if (out_mem_access_req !== 1'b0) begin miscompares++; $display("FAIL hit_memreq got %0b want 0", out_mem_access_req); end
    vectors++; if (out_busy !== 1'b0) begin miscompares++; $display("FAIL hit_busy got %0b want 0", out_busy); end
  endtask

  task automatic test_back_to_back;
    in_req_read_req  = 1'b1;
    in_req_read_addr = 64'h1000;
    @(negedge clk);
    vectors++; if (out_req_read_valid !== 1'b1) begin miscompares++; $display("FAIL b2b0_valid got %0b want 1", out_req_read_valid); end
    vectors++; if (out_req_read_instr !== 32'h10000000) begin miscompares++; $display("FAIL b2b0_instr got %h want 10000000", out_req_read_instr); end
    in_req_read_addr = 64'h1008;
    @(negedge clk);
    in_req_read_req = 1'b0;
    vectors++; if (out_req_read_valid !== 1'b1) begin miscompares++; $display("FAIL b2b1_valid got %0b want 1", out_req_read_valid); end
    vectors++; if (out_req_read_instr !== 32'h12020202) begin miscompares++; $display("FAIL b2b1_instr got %h want 12020202", out_req_read_instr); end
    @(negedge clk);
    vectors++; if (out_req_read_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_end got %0b want 0", out_req_read_valid); end
  endtask

  task automatic test_stray_mem_valid;
    in_mem_access_valid = 1'b1;
    in_mem_access_data  = '1;
    @(negedge clk);
    in_mem_access_valid = 1'b0;
    vectors++; if (out_req_read_valid !== 1'b0) begin miscompares++; $display("FAIL stray_valid got %0b want 0", out_req_read_valid); end
    issue_read(64'h1004);
    vectors++; if (out_req_read_instr !== 32'hDEADBEEF || out_req_read_valid !== 1'b1) begin
      miscompares++; $display("FAIL stray_hit got %0b/%h want 1/deadbeef", out_req_read_valid, out_req_read_instr); end
  endtask

  task automatic test_eviction;
    issue_read(64'h2004);
    vectors++; if (out_mem_access_req !== 1'b1) begin miscompares++; $display("FAIL evict_memreq got %0b want 1", out_mem_access_req); end
    vectors++; if (out_mem_access_addr !== 64'h2000) begin miscompares++; $display("FAIL evict_memaddr got %h want 2000", out_mem_access_addr); end
    respond(line2000);
    vectors++; if (out_req_read_instr !== 32'h21010101) begin miscompares++; $display("FAIL evict_instr got %h want 21010101", out_req_read_instr); end
    @(negedge clk);
    issue_read(64'h1004);
    vectors++; if (out_mem_access_req !== 1'b1) begin miscompares++; $display("FAIL evicted_miss got %0b want 1", out_mem_access_req); end
    vectors++; if (out_mem_access_addr !== 64'h1000) begin miscompares++; $display("FAIL evicted_addr got %h want 1000", out_mem_access_addr); end
    respond(line1000);
    vectors++; if (out_req_read_instr !== 32'hDEADBEEF) begin miscompares++; $display("FAIL refill_instr got %h want deadbeef", out_req_read_instr); end
    @(negedge clk);
  endtask

  task automatic test_flush;
    int busy_cycles;
    in_flush_req = 1'b1;
    @(negedge clk);
    in_flush_req = 1'b0;
    busy_cycles = 0;
    while (out_busy === 1'b1 && busy_cycles < 100) begin
      busy_cycles++;
      @(negedge clk);
    end
    vectors++; if (busy_cycles != 32) begin miscompares++; $display("FAIL flush_busy_cycles got %0d want 32", busy_cycles); end
    issue_read(64'h1004);
    vectors++; if (out_mem_access_req !== 1'b1) begin miscompares++; $display("FAIL postflush_miss got %0b want 1", out_mem_access_req); end
    respond(line1000);
    vectors++; if (out_req_read_instr !== 32'hDEADBEEF) begin miscompares++; $display("FAIL postflush_instr got %h want deadbeef", out_req_read_instr); end
    @(negedge clk);
  endtask

  task automatic test_flush_with_read;
    int busy_cycles;
    int spurious;
    in_flush_req     = 1'b1;
    in_req_read_req  = 1'b1;
    in_req_read_addr = 64'h1004;
    @(negedge clk);
    in_flush_req = 1'b0;
    vectors++; if (out_busy !== 1'b1 || out_mem_access_req !== 1'b0) begin
      miscompares++; $display("FAIL flushrd_state got busy=%0b memreq=%0b want 1/0", out_busy, out_mem_access_req); end
    busy_cycles = 0;
    spurious = 0;
    while (out_busy === 1'b1 && busy_cycles < 100) begin
      if (out_req_read_valid !== 1'b0) spurious++;
      busy_cycles++;
      @(negedge clk);
    end
    vectors++; if (spurious != 0) begin miscompares++; $display("FAIL flushrd_valid got %0d pulses want 0", spurious); end
    vectors++; if (busy_cycles != 32) begin miscompares++; $display("FAIL flushrd_busy_cycles got %0d want 32", busy_cycles); end
    @(negedge clk);
    in_req_read_req = 1'b0;
    vectors++; if (out_mem_access_req !== 1'b1) begin miscompares++; $display("FAIL heldread_miss got %0b want 1", out_mem_access_req); end
    vectors++; if (out_mem_access_addr !== 64'h1000) begin miscompares++; $display("FAIL heldread_addr got %h want 1000", out_mem_access_addr); end
    respond(line1000);
    vectors++; if (out_req_read_valid !== 1'b1 || out_req_read_instr !== 32'hDEADBEEF) begin
      miscompares++; $display("FAIL heldread_resp got %0b/%h want 1/deadbeef", out_req_read_valid, out_req_read_instr); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_fill;
    issue_read(64'h2004);
    vectors++; if (out_mem_access_req !== 1'b1) begin miscompares++; $display("FAIL rstfill_memreq got %0b want 1", out_mem_access_req); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (out_mem_access_req !== 1'b0) begin miscompares++; $display("FAIL rstfill_memreq_drop got %0b want 0", out_mem_access_req); end
    vectors++; if (out_busy !== 1'b0) begin miscompares++; $display("FAIL rstfill_busy_drop got %0b want 0", out_busy); end
    in_mem_access_valid = 1'b1;
    in_mem_access_data  = line2000;
    @(negedge clk);
    in_mem_access_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (out_req_read_valid !== 1'b0) begin miscompares++; $display("FAIL rstfill_spurious got %0b want 0", out_req_read_valid); end
    issue_read(64'h1004);
    vectors++; if (out_mem_access_req !== 1'b1) begin miscompares++; $display("FAIL postrst_miss got %0b want 1", out_mem_access_req); end
    respond(line1000);
    vectors++; if (out_req_read_instr !== 32'hDEADBEEF) begin miscompares++; $display("FAIL postrst_instr got %h want deadbeef", out_req_read_instr); end
  endtask

  initial begin
    line1000 = gen_line(32'h1000_0000);
    line1000[63:32] = 32'hDEADBEEF;
    line2000 = gen_line(32'h2000_0000);
    test_reset;
    test_miss_fill;
    test_hit;
    test_back_to_back;
    test_stray_mem_valid;
    test_eviction;
    test_flush;
    test_flush_with_read;
    test_reset_mid_fill;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
